video_ram_banked: RTL and testbench



---
 rtl/video_ram_banked.sv | 226 ++++++++++++++++++++++
 tb/tb_video_ram_banked.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_ram_banked.sv
// Banked dual-port byte video RAM with a fill/copy engine sharing port B.
// Port A feeds the fetch pipeline and is never stalled by the engine.

module video_ram_bank #(
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       en_a_i,
    input  logic                       we_a_i,
    input  logic [BANK_ADDR_WIDTH-1:0] addr_a_i,
    input  logic [DATA_WIDTH-1:0]      din_a_i,
    output logic [DATA_WIDTH-1:0]      rd_a_o,
    input  logic                       en_b_i,
    input  logic                       we_b_i,
    input  logic [BANK_ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0]      din_b_i,
    output logic [DATA_WIDTH-1:0]      rd_b_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**BANK_ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;

    // Read-first on both ports; port A is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (en_a_i) rd_a_q <= mem_q[addr_a_i];
        if (en_b_i) rd_b_q <= mem_q[addr_b_i];
        if (en_b_i && we_b_i) mem_q[addr_b_i] <= din_b_i;
        if (en_a_i && we_a_i) mem_q[addr_a_i] <= din_a_i;
    end

    assign rd_a_o = rd_a_q;
    assign rd_b_o = rd_b_q;
endmodule

module video_ram_banked #(
    parameter int ADDR_WIDTH      = 15,
    parameter int DATA_WIDTH      = 8,
    parameter int BANK_ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    input  logic                  op_start,
    input  logic                  op_copy,
    input  logic [ADDR_WIDTH-1:0] op_src,
    input  logic [ADDR_WIDTH-1:0] op_dst,
    input  logic [ADDR_WIDTH-1:0] op_len,
    input  logic [DATA_WIDTH-1:0] op_fill,
    output logic                  op_busy,
    output logic                  op_done
);
    localparam int NUM_BANKS = 2**(ADDR_WIDTH-BANK_ADDR_WIDTH);
    localparam int SEL_W     = (ADDR_WIDTH > BANK_ADDR_WIDTH) ? ADDR_WIDTH-BANK_ADDR_WIDTH : 1;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CRD, S_CWR, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  done_q, done_d;

    logic                  eng_own;
    logic [ADDR_WIDTH-1:0] pb_addr;
    logic                  pb_we;
    logic [DATA_WIDTH-1:0] pb_din;

    logic [SEL_W-1:0]      sel_a, sel_b, sel_a_q, sel_b_q;
    logic                  vld_a_q, host_b_q;
    logic [DATA_WIDTH-1:0] hold_b_q;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

    logic [NUM_BANKS-1:0]                 en_a, en_b;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rd_a, rd_b;

    assign eng_own = (state_q == S_FILL) || (state_q == S_CRD) || (state_q == S_CWR);

    // Port B owner mux: the engine takes the port in FILL/CRD/CWR, so host writes drop.
    always_comb begin
        pb_addr = addr_b;
        pb_we   = we_b;
        pb_din  = din_b;
        case (state_q)
            S_FILL: begin
                pb_addr = dst_q;
                pb_we   = 1'b1;
                pb_din  = fill_q;
            end
            S_CRD: begin
                pb_addr = src_q;
                pb_we   = 1'b0;
            end
            S_CWR: begin
                pb_addr = dst_q;
                pb_we   = 1'b1;
                pb_din  = rdata_b;
            end
            default: ;
        endcase
    end

    generate
        if (ADDR_WIDTH > BANK_ADDR_WIDTH) begin : g_multi
            assign sel_a = addr_a[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
            assign sel_b = pb_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
        end else begin : g_single
            assign sel_a = '0;
            assign sel_b = '0;
        end
    endgenerate

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        assign en_a[g] = (sel_a == SEL_W'(g));
        assign en_b[g] = (sel_b == SEL_W'(g));

        video_ram_bank #(
            .BANK_ADDR_WIDTH(BANK_ADDR_WIDTH),
            .DATA_WIDTH     (DATA_WIDTH)
        ) u_bank (
            .clk     (clk),
            .en_a_i  (en_a[g]),
            .we_a_i  (we_a),
            .addr_a_i(addr_a[BANK_ADDR_WIDTH-1:0]),
            .din_a_i (din_a),
            .rd_a_o  (rd_a[g]),
            .en_b_i  (en_b[g]),
            .we_b_i  (pb_we),
            .addr_b_i(pb_addr[BANK_ADDR_WIDTH-1:0]),
            .din_b_i (pb_din),
            .rd_b_o  (rd_b[g])
        );
    end

    assign rdata_a = rd_a[sel_a_q];
    assign rdata_b = rd_b[sel_b_q];

    // Bank registers are not reset, so the outputs are gated until a real read lands.
    // dout_b falls back to its last host value whenever the engine owned the port.
    assign dout_a  = vld_a_q  ? rdata_a : '0;
    assign dout_b  = host_b_q ? rdata_b : hold_b_q;
    assign op_busy = eng_own;
    assign op_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            vld_a_q  <= 1'b0;
            host_b_q <= 1'b0;
            hold_b_q <= '0;
        end else begin
            sel_a_q  <= sel_a;
            sel_b_q  <= sel_b;
            vld_a_q  <= 1'b1;
            host_b_q <= !eng_own;
            hold_b_q <= dout_b;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        done_d  = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                // A start landing on the op_done cycle is dropped.
                if (op_start && !done_q) begin
                    if (op_len == '0) begin
                        state_d = S_DONE;
                    end else if (!op_copy) begin
                        dst_d   = op_dst;
                        len_d   = op_len;
                        fill_d  = op_fill;
                        state_d = S_FILL;
                    end else begin
                        src_d   = op_src;
                        dst_d   = op_dst;
                        len_d   = op_len;
                        state_d = S_CRD;
                    end
                end
            end
            S_FILL: begin
                dst_d = dst_q + 1'b1;
                len_d = len_q - 1'b1;
                if (len_q == ADDR_WIDTH'(1)) state_d = S_DONE;
            end
            S_CRD: state_d = S_CWR;
            S_CWR: begin
                src_d   = src_q + 1'b1;
                dst_d   = dst_q + 1'b1;
                len_d   = len_q - 1'b1;
                state_d = (len_q == ADDR_WIDTH'(1)) ? S_DONE : S_CRD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_video_ram_banked.sv
// Bench for video_ram_banked: vector table, hand-written engine corner cases,
// and random traffic checked against an associative-array memory model.

module tb_video_ram_banked;
    localparam int AW   = 15;
    localparam int DW   = 8;
    localparam int MASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          we_a = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;
    logic [DW-1:0] dout_a, dout_b;
    logic          op_start = 1'b0, op_copy = 1'b0;
    logic [AW-1:0] op_src = '0, op_dst = '0, op_len = '0;
    logic [DW-1:0] op_fill = '0;
    logic          op_busy, op_done;

    int total = 0;
    int bad   = 0;
    logic [7:0] mdl [int];

    video_ram_banked #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_ADDR_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
        .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b),
        .op_start(op_start), .op_copy(op_copy), .op_src(op_src), .op_dst(op_dst),
        .op_len(op_len), .op_fill(op_fill), .op_busy(op_busy), .op_done(op_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic       we_a;
        int         aa;
        logic [7:0] da;
        logic       we_b;
        int         ab;
        logic [7:0] db;
        logic       ca;
        logic [7:0] ea;
        logic       cb;
        logic [7:0] eb;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input int a, input logic [7:0] d);
        we_a = 1'b1; addr_a = AW'(a); din_a = d;
        step();
        we_a = 1'b0;
        mdl[a & MASK] = d;
    endtask

    task automatic rd_a_chk(input string nm, input int a);
        int m;
        m = a & MASK;
        we_a = 1'b0; addr_a = AW'(m);
        step();
        if (mdl.exists(m)) chk(nm, dout_a, mdl[m]);
        else chk({nm, " unknown-addr"}, 0, 1);
    endtask

    // Launch one engine op; check busy/done every cycle and that dout_b holds.
    task automatic run_op(input string nm, input bit cp, input int src, input int dst,
                          input int len, input logic [7:0] fv);
        int busy_n, done_k;
        logic [7:0] held;
        busy_n = (len == 0) ? 0 : (cp ? 2*len : len);
        done_k = (len == 0) ? 1 : (cp ? 2*len+1 : len+1);
        for (int i = 0; i < len; i++) begin
            int s, d;
            s = (src + i) & MASK;
            d = (dst + i) & MASK;
            if (!cp) mdl[d] = fv;
            else if (mdl.exists(s)) mdl[d] = mdl[s];
            else mdl.delete(d);
        end
        addr_b = AW'('h0FFF); we_b = 1'b0;
        op_copy = cp; op_src = AW'(src); op_dst = AW'(dst); op_len = AW'(len); op_fill = fv;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        held = dout_b;
        for (int k = 0; k <= done_k + 1; k++) begin
            if (k > 0) step();
            chk({nm, " busy"}, op_busy, (k < busy_n) ? 1 : 0);
            chk({nm, " done"}, op_done, (k == done_k) ? 1 : 0);
            if (k > 0 && k <= busy_n) chk({nm, " dout_b hold"}, dout_b, held);
        end
    endtask

    initial begin
        int base [4];
        base[0] = 'h0FFC; base[1] = 'h0200; base[2] = 'h7FFC; base[3] = 'h0000;

        vt[0] = '{1'b1, 'h0FFF, 8'h5A, 1'b0, 'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        vt[1] = '{1'b1, 'h1000, 8'hA5, 1'b0, 'h0FFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A};
        vt[2] = '{1'b1, 'h0200, 8'h33, 1'b0, 'h1000, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5};
        vt[3] = '{1'b1, 'h0200, 8'h11, 1'b1, 'h0200, 8'h22, 1'b1, 8'h33, 1'b1, 8'h33};
        vt[4] = '{1'b0, 'h0200, 8'h00, 1'b0, 'h0200, 8'h00, 1'b1, 8'h11, 1'b1, 8'h11};
        vt[5] = '{1'b0, 'h0FFF, 8'h00, 1'b1, 'h0FFF, 8'h77, 1'b1, 8'h5A, 1'b1, 8'h5A};
        vt[6] = '{1'b0, 'h0FFF, 8'h00, 1'b0, 'h1000, 8'h00, 1'b1, 8'h77, 1'b1, 8'hA5};

        // Reset state
        #2 rst_n = 1'b0;
        step();
        step();
        chk("reset dout_a", dout_a, 0);
        chk("reset dout_b", dout_b, 0);
        chk("reset busy", op_busy, 0);
        chk("reset done", op_done, 0);
        rst_n = 1'b1;

        // Vector table: bank boundary, read-first, A-wins collision
        foreach (vt[i]) begin
            we_a = vt[i].we_a; addr_a = AW'(vt[i].aa); din_a = vt[i].da;
            we_b = vt[i].we_b; addr_b = AW'(vt[i].ab); din_b = vt[i].db;
            step();
            if (vt[i].ca) chk($sformatf("vec%0d dout_a", i), dout_a, vt[i].ea);
            if (vt[i].cb) chk($sformatf("vec%0d dout_b", i), dout_b, vt[i].eb);
            if (vt[i].we_b) mdl[vt[i].ab] = vt[i].db;
            if (vt[i].we_a) mdl[vt[i].aa] = vt[i].da;
        end
        we_a = 1'b0; we_b = 1'b0;

        // Fill wrapping past the top of memory
        wr_a('h7FFD, 8'h3D);
        wr_a('h0002, 8'h02);
        run_op("fill_wrap", 1'b0, 0, 'h7FFE, 4, 8'hEE);
        rd_a_chk("fill 7FFE", 'h7FFE);
        rd_a_chk("fill 7FFF", 'h7FFF);
        rd_a_chk("fill 0000", 'h0000);
        rd_a_chk("fill 0001", 'h0001);
        rd_a_chk("fill 0002 untouched", 'h0002);
        rd_a_chk("fill 7FFD untouched", 'h7FFD);

        // Overlapping forward copy smears the first byte
        wr_a('h0100, 8'h01);
        wr_a('h0101, 8'hB1);
        wr_a('h0104, 8'h44);
        run_op("copy_smear", 1'b1, 'h0100, 'h0101, 3, 8'h00);
        rd_a_chk("smear 0101", 'h0101);
        rd_a_chk("smear 0102", 'h0102);
        rd_a_chk("smear 0103", 'h0103);
        rd_a_chk("smear 0104 untouched", 'h0104);

        // Zero-length op
        wr_a('h2000, 8'h5C);
        run_op("len0", 1'b0, 0, 'h2000, 0, 8'h99);
        rd_a_chk("len0 mem", 'h2000);

        // Start during op_done is dropped; next cycle it is taken
        op_copy = 1'b0; op_dst = AW'('h3000); op_len = AW'(1); op_fill = 8'h21;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        step();
        step();
        chk("seq done pulse", op_done, 1);
        op_dst = AW'('h3001); op_fill = 8'h22; op_start = 1'b1;
        step();
        chk("start on done ignored", op_busy, 0);
        step();
        op_start = 1'b0;
        chk("start after done taken", op_busy, 1);
        step();
        step();
        chk("second done", op_done, 1);
        mdl['h3000] = 8'h21;
        mdl['h3001] = 8'h22;
        rd_a_chk("seq 3000", 'h3000);
        rd_a_chk("seq 3001", 'h3001);

        // Long fill: host write and re-start ignored, then reset mid-flight
        wr_a('h0050, 8'h5F);
        wr_a(50, 8'h66);
        wr_a('h6000, 8'h34);
        addr_b = AW'('h0050); din_b = 8'h99;
        op_copy = 1'b0; op_dst = '0; op_len = AW'(100); op_fill = 8'hC3;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            we_b = (k == 10);
            if (k == 20) begin
                op_start = 1'b1; op_dst = AW'('h6000); op_len = AW'(5); op_fill = 8'h12;
            end
            step();
            op_start = 1'b0;
            chk($sformatf("long fill busy k=%0d", k), op_busy, 1);
        end
        we_b = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort busy", op_busy, 0);
        chk("abort done", op_done, 0);
        chk("abort dout_a", dout_a, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post-abort done", op_done, 0);
            chk("post-abort busy", op_busy, 0);
        end
        for (int i = 0; i < 50; i++) mdl[i] = 8'hC3;
        rd_a_chk("abort byte 0", 0);
        rd_a_chk("abort byte 25", 25);
        rd_a_chk("abort byte 49", 49);
        rd_a_chk("abort byte 50 untouched", 50);
        rd_a_chk("host we_b dropped", 'h0050);
        rd_a_chk("restart dropped", 'h6000);

        // Random host traffic on both ports around bank edges
        for (int n = 0; n < 300; n++) begin
            int aa, ab;
            logic [7:0] da, db, ea, eb;
            bit ka, kb, wa, wb;
            aa = (base[$urandom_range(0, 3)] + $urandom_range(0, 7)) & MASK;
            ab = (base[$urandom_range(0, 3)] + $urandom_range(0, 7)) & MASK;
            da = 8'($urandom); db = 8'($urandom);
            wa = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
            ka = mdl.exists(aa); kb = mdl.exists(ab);
            ea = ka ? mdl[aa] : 8'h00;
            eb = kb ? mdl[ab] : 8'h00;
            if (wb) mdl[ab] = db;
            if (wa) mdl[aa] = da;
            we_a = wa; addr_a = AW'(aa); din_a = da;
            we_b = wb; addr_b = AW'(ab); din_b = db;
            step();
            if (ka) chk($sformatf("rand A @%0h", aa), dout_a, ea);
            if (kb) chk($sformatf("rand B @%0h", ab), dout_b, eb);
        end
        we_a = 1'b0; we_b = 1'b0;

        // Random fills and copies
        for (int n = 0; n < 8; n++) begin
            bit cp;
            int len, src, dst;
            cp  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            src = $urandom_range(0, MASK);
            dst = $urandom_range(0, 1) ? ((src + $urandom_range(1, len)) & MASK)
                                       : $urandom_range(0, MASK);
            if (cp) for (int i = 0; i < len; i++) wr_a(src + i, 8'($urandom));
            run_op($sformatf("rand op%0d", n), cp, src, dst, len, 8'($urandom));
            for (int i = 0; i < len; i++) rd_a_chk($sformatf("rand op%0d byte%0d", n, i), dst + i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
